// File: rtl/mips_multicycle_control.sv
// Moore control FSM for a shared multi-cycle MIPS datapath (R-type ALU ops and addi),
// with run/halt sequencing, illegal-instruction trap and retire/active-cycle counters.
module mips_multicycle_control (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        run,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    output logic        pc_write,
    output logic        ir_write,
    output logic        ab_write,
    output logic        aluout_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        busy,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] instret,
    output logic [31:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC_R = 3'd3,
        S_EXEC_I = 3'd4,
        S_WB_R   = 3'd5,
        S_WB_I   = 3'd6,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] instret_reg;
    logic [31:0] cycle_reg;
    logic        funct_ok;
    logic        in_wb;
    logic        active;

    assign funct_ok = (funct == 6'd32) || (funct == 6'd34) || (funct == 6'd36) ||
                      (funct == 6'd37) || (funct == 6'd39) || (funct == 6'd42);
    assign in_wb    = (state_reg == S_WB_R) || (state_reg == S_WB_I);
    assign active   = (state_reg != S_IDLE) && (state_reg != S_TRAP);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg   <= S_IDLE;
            instret_reg <= 32'd0;
            cycle_reg   <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (active) begin
                cycle_reg <= cycle_reg + 32'd1;
            end
            // Every exit from a write-back state retires exactly one instruction.
            if (in_wb) begin
                instret_reg <= instret_reg + 32'd1;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_write     = 1'b0;
        ir_write     = 1'b0;
        ab_write     = 1'b0;
        aluout_write = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 2'b00;
        alu_op       = 2'b00;
        illegal      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (run) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'b01;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                ab_write = 1'b1;
                if (op == OP_RTYPE && funct_ok) begin
                    state_next = S_EXEC_R;
                end else if (op == OP_ADDI) begin
                    state_next = S_EXEC_I;
                end else begin
                    state_next = S_TRAP;
                end
            end
            S_EXEC_R: begin
                alu_src_a    = 1'b1;
                alu_op       = 2'b10;
                aluout_write = 1'b1;
                state_next   = S_WB_R;
            end
            S_EXEC_I: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                aluout_write = 1'b1;
                state_next   = S_WB_I;
            end
            S_WB_R: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                state_next = run ? S_FETCH : S_IDLE;
            end
            S_WB_I: begin
                reg_write  = 1'b1;
                state_next = run ? S_FETCH : S_IDLE;
            end
            default: begin
                // TRAP holds until reset.
                illegal    = 1'b1;
                state_next = S_TRAP;
            end
        endcase
    end

    assign busy        = active;
    assign state       = state_reg;
    assign instret     = instret_reg;
    assign cycle_count = cycle_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: expected per-cycle state, control word
// and counters are queued as stimulus is driven and compared one cycle later.
module tb_mips_multicycle_control;

    logic        clock;
    logic        reset_n;
    logic        run;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        pc_write, ir_write, ab_write, aluout_write, reg_write, reg_dst;
    logic        alu_src_a, busy, illegal;
    logic [1:0]  alu_src_b, alu_op;
    logic [2:0]  state;
    logic [31:0] instret, cycle_count;

    mips_multicycle_control dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .run          (run),
        .op           (op),
        .funct        (funct),
        .pc_write     (pc_write),
        .ir_write     (ir_write),
        .ab_write     (ab_write),
        .aluout_write (aluout_write),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .busy         (busy),
        .illegal      (illegal),
        .state        (state),
        .instret      (instret),
        .cycle_count  (cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC_R = 3'd3,
                           EXEC_I = 3'd4, WB_R = 3'd5, WB_I = 3'd6, TRAP = 3'd7;

    typedef struct {
        logic [2:0]  st;
        logic [31:0] cyc;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb[$];
    int          tests_run = 0;
    int          tests_failed = 0;
    int          reg_write_pulses = 0;
    logic [2:0]  m_prev;
    logic [31:0] m_cyc, m_ret;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // {pc_write, ir_write, ab_write, aluout_write, reg_write, reg_dst,
    //  alu_src_a, alu_src_b[1:0], alu_op[1:0], busy, illegal}
    function automatic logic [12:0] ctrl_of(input logic [2:0] s);
        case (s)
            FETCH:   return 13'b1100000_01_00_10;
            DECODE:  return 13'b0010000_00_00_10;
            EXEC_R:  return 13'b0001001_00_10_10;
            EXEC_I:  return 13'b0001001_10_00_10;
            WB_R:    return 13'b0000110_00_00_10;
            WB_I:    return 13'b0000100_00_00_10;
            TRAP:    return 13'b0000000_00_00_01;
            default: return 13'b0000000_00_00_00;
        endcase
    endfunction

    // Expected state after the next edge; counters advance based on the state being left.
    task automatic push(input logic [2:0] s);
        exp_t e;
        if (m_prev >= FETCH && m_prev <= WB_I) m_cyc = m_cyc + 32'd1;
        if (m_prev == WB_R || m_prev == WB_I) m_ret = m_ret + 32'd1;
        e.st = s; e.cyc = m_cyc; e.ret = m_ret;
        sb.push_back(e);
        m_prev = s;
    endtask

    task automatic push_reset();
        exp_t e;
        m_cyc = 0; m_ret = 0; m_prev = IDLE;
        e.st = IDLE; e.cyc = 0; e.ret = 0;
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clock);
        #1;
        if (reg_write) reg_write_pulses++;
        if (sb.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_val("state", {29'd0, state}, {29'd0, e.st});
            check_val("ctrl", {19'd0, pc_write, ir_write, ab_write, aluout_write, reg_write,
                      reg_dst, alu_src_a, alu_src_b, alu_op, busy, illegal},
                      {19'd0, ctrl_of(e.st)});
            check_val("cycle_count", cycle_count, e.cyc);
            check_val("instret", instret, e.ret);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        run = 1'b0;
        push_reset(); step();
        push_reset(); step();
        reset_n = 1'b1;
    endtask

    // Runs one legal instruction starting from IDLE/WB with run already high.
    task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic is_r);
        op = o; funct = f;
        push(FETCH);  step();
        push(DECODE); step();
        push(is_r ? EXEC_R : EXEC_I); step();
        push(is_r ? WB_R : WB_I);     step();
        $display("[TB] instr op=%0h funct=%0h instret=%0d cycles=%0d", o, f, instret, cycle_count);
    endtask

    task automatic do_illegal(input logic [5:0] o, input logic [5:0] f);
        int rw0;
        logic [31:0] ret0;
        op = o; funct = f;
        run = 1'b1;
        push(FETCH);  step();
        push(DECODE); step();
        ret0 = instret;
        rw0 = reg_write_pulses;
        push(TRAP);   step();
        for (int i = 0; i < 10; i++) begin
            push(TRAP); step();
        end
        check_val("trap_instret", instret, ret0);
        check_val("trap_regwrite", reg_write_pulses, rw0);
        $display("[TB] illegal op=%0h funct=%0h state=%0d illegal=%0b", o, f, state, illegal);
        do_reset();
        check_val("post_trap_illegal", {31'd0, illegal}, 32'd0);
    endtask

    logic [5:0] r_funct[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    logic [5:0] seq_op[9]  = '{6'h08, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    logic [5:0] seq_fn[9]  = '{6'h00, 6'h00, 6'h24, 6'h22, 6'h25, 6'h20, 6'h27, 6'h2A, 6'h2A};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rw0;
        m_prev = IDLE; m_cyc = 0; m_ret = 0;
        reset_n = 1'b0; run = 1'b0; op = 6'h08; funct = 6'h00;
        do_reset();

        // addi from IDLE, then halt
        run = 1'b1;
        do_instr(6'h08, 6'h00, 1'b0);
        run = 1'b0;
        push(IDLE); step();
        check_val("addi_instret", instret, 32'd1);
        check_val("addi_cycles", cycle_count, 32'd4);
        push(IDLE); step();

        // every legal funct back-to-back
        run = 1'b1;
        for (int i = 0; i < 6; i++) do_instr(6'h00, r_funct[i], 1'b1);
        run = 1'b0;
        push(IDLE); step();

        // 9-instruction program
        do_reset();
        rw0 = reg_write_pulses;
        run = 1'b1;
        for (int i = 0; i < 9; i++) do_instr(seq_op[i], seq_fn[i], seq_op[i] == 6'h00);
        run = 1'b0;
        push(IDLE); step();
        check_val("seq_instret", instret, 32'd9);
        check_val("seq_cycles", cycle_count, 32'd36);
        check_val("seq_regwrites", reg_write_pulses - rw0, 32'd9);

        // run dropped during DECODE still completes the instruction
        do_reset();
        rw0 = reg_write_pulses;
        op = 6'h08; funct = 6'h00;
        run = 1'b1;
        push(FETCH);  step();
        push(DECODE); step();
        run = 1'b0;
        push(EXEC_I); step();
        push(WB_I);   step();
        push(IDLE);   step();
        push(IDLE);   step();
        check_val("halt_regwrites", reg_write_pulses - rw0, 32'd1);
        run = 1'b1;
        do_instr(6'h08, 6'h00, 1'b0);
        run = 1'b0;
        push(IDLE); step();

        // illegal instructions: lw and jr
        do_illegal(6'h23, 6'h00);
        do_illegal(6'h00, 6'h08);

        // reset in EXEC_R suppresses write-back
        rw0 = reg_write_pulses;
        op = 6'h00; funct = 6'h20;
        run = 1'b1;
        push(FETCH);  step();
        push(DECODE); step();
        push(EXEC_R); step();
        reset_n = 1'b0;
        push_reset(); step();
        reset_n = 1'b1;
        run = 1'b0;
        push(IDLE); step();
        check_val("rst_exec_regwrites", reg_write_pulses - rw0, 32'd0);
        check_val("rst_exec_instret", instret, 32'd0);
        check_val("rst_exec_cycles", cycle_count, 32'd0);
        check_val("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Moore-style control FSM that sequences a shared, multi-cycle MIPS datapath for R-type (add, sub, and, or, nor, slt) and addi instructions. A single ALU handles PC increment, register-operand compute and immediate compute in different cycles. The FSM sits beside the datapath, decodes opcode and function fields from the latched IR, and drives every write enable and mux select. It also provides run/halt sequencing, illegal-instruction trapping and retired-instruction / active-cycle counters.

## Interface
- No parameters.
- clock  in  1  sole clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- run  in  1  level; 1 = execute instructions, 0 = halt at next instruction boundary
- op  in  6  IR[31:26] from latched IR
- funct  in  6  IR[5:0] from latched IR
- pc_write  out  1  load PC with ALU result
- ir_write  out  1  latch instruction memory output into IR
- ab_write  out  1  latch register-file RD1/RD2 into A/B
- aluout_write  out  1  latch ALU result into ALUOut register
- reg_write  out  1  register-file write enable
- reg_dst  out  1  1 = rd (IR[15:11]), 0 = rt (IR[20:16])
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = constant 4, 10 = sign-extended imm16, 11 = reserved/unused
- alu_op  out  2  00 = add, 01 = sub, 10 = decode funct (ALU control unit)
- busy  out  1  state not IDLE and not TRAP
- illegal  out  1  sticky; 1 while in TRAP
- state  out  3  current state encoding, for debug
- instret  out  32  retired-instruction count
- cycle_count  out  32  count of cycles spent in FETCH..WB states

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC_R=3, EXEC_I=4, WB_R=5, WB_I=6, TRAP=7.
- Outputs are pure functions of state. Any output not listed for a state is 0.
- IDLE: no outputs asserted. run=1 → FETCH; otherwise stay in IDLE.
- FETCH: ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=01, alu_op=00. Always → DECODE.
- DECODE: ab_write=1.
  - op=000000 with funct ∈ {32,34,36,37,39,42} → EXEC_R.
  - op=001000 → EXEC_I.
  - Anything else → TRAP.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10, aluout_write=1. → WB_R.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=00, aluout_write=1. → WB_I.
- WB_R: reg_write=1, reg_dst=1. WB_I: reg_write=1, reg_dst=0.
  - From either WB state: run=1 → FETCH; run=0 → IDLE.
- TRAP: illegal=1 and all enables 0. Exits only via reset.
- run is sampled only in IDLE and in the WB states. Dropping run mid-instruction always completes that instruction; there is no partial retirement.
- instret increments by 1 on the rising edge that leaves WB_R or WB_I. It wraps 0xFFFFFFFF → 0.
- cycle_count increments by 1 on every rising edge whose current state is in FETCH..WB_I. It does not increment in IDLE or TRAP, and wraps modulo 2^32.
- An illegal instruction does not increment instret. Its FETCH and DECODE cycles are counted in cycle_count.

## Timing
- Reset: reset_n=0 at a rising edge forces state=IDLE, instret=0, cycle_count=0, illegal=0. Reset overrides every other condition, including mid-instruction and TRAP.
  - All enables are 0 combinationally once state=IDLE, so an instruction interrupted by reset never asserts reg_write.
- Enables asserted during a state take effect at the rising edge that ends that state.
- CPI is fixed at 4 (FETCH, DECODE, EXEC, WB).
- run rises while in IDLE: FETCH follows in the next cycle, so the first ir_write comes 1 cycle after run is sampled high.
- Back-to-back instructions with run held at 1: WB → FETCH with no bubble.
- Illegal instruction: TRAP is entered 2 cycles after FETCH; illegal goes high in that cycle.

## Test plan
- Reset, then run=1 with op=001000 (addi $t1,$0,15): state sequence 0,1,2,4,6,1. In WB_I, reg_write=1 and reg_dst=0. After that cycle, instret=1 and cycle_count=4.
- R-type op=000000, funct=0x24 (and): EXEC_R drives alu_src_a=1, alu_src_b=00, alu_op=10. WB_R drives reg_write=1 and reg_dst=1. Check each funct in {0x20,0x22,0x24,0x25,0x27,0x2A} reaches WB_R.
- Full 9-instruction sequence (2×addi, then and, sub, or, add, nor, slt, slt) with run held at 1: after 36 cycles instret=9 and cycle_count=36, with exactly 9 reg_write pulses.
- op=100011 (lw) or op=0 with funct=0x08 (jr): DECODE → TRAP, illegal=1, busy=0, instret unchanged. State stays 7 for 10+ cycles with run=1; reset_n=0 returns to state 0 with illegal=0.
- Drop run to 0 during DECODE: the instruction completes WB (reg_write pulses once), then state=0 and busy=0. Re-assert run: FETCH on the next cycle.
- reset_n=0 during EXEC_R: next state is IDLE, no reg_write pulse occurs, and instret and cycle_count both read 0.
